batch_readout: RTL and testbench

Frame serializer at the consumer end of the batch monitor. On each `batch_done` pulse it snapshots all per-channel coincidence counters and streams them as one framed byte sequence over a valid/ready byte interface to the host-link transmitter (UART TX). It carries data from the counting core to the PC, and flags batches it cannot send.

---
 rtl/coinc_pkg.sv | 18 +
 rtl/batch_readout.sv | 132 +++++++++++++
 tb/tb_batch_readout.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coinc_pkg.sv
// rtl/coinc_pkg.sv - shared constants and types for the coincidence counting core
// Holds the frame header, the readout state enum and default channel geometry.
package coinc_pkg;

   localparam int NUM_CH_DEF = 9;
   localparam int CNT_W_DEF  = 32;

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_HDR,
      RD_SEQ,
      RD_DATA,
      RD_CSUM
   } rd_state_t;

endpackage

// File: rtl/batch_readout.sv
// rtl/batch_readout.sv - snapshots counters on batch_done and streams them as a framed byte sequence
// Frame: header, seq, channel bytes MSB first, XOR checksum over seq and data.
module batch_readout
   import coinc_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    batch_done,
   input  logic [NUM_CH*CNT_W-1:0] counts,
   input  logic                    overrun_clr,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic                    overrun
);

   localparam int BPC    = CNT_W / 8;
   localparam int NBYTES = NUM_CH * BPC;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   rd_state_t               state_q;
   logic [NUM_CH*CNT_W-1:0] snap_q;
   logic [IDX_W-1:0]        idx_q;
   logic [7:0]              seq_q;
   logic [7:0]              csum_q;
   logic [7:0]              tx_data_q;
   logic                    tx_valid_q;
   logic                    busy_q;
   logic                    overrun_q;

   logic hs;
   logic csum_accept;
   logic start;
   logic drop;

   // Data byte idx of the snapshot: channel-major, most significant byte first.
   function automatic logic [7:0] snap_byte(input logic [NUM_CH*CNT_W-1:0] s,
                                            input logic [IDX_W-1:0]        idx);
      int i;
      int ch;
      int b;
      i  = int'(idx);
      ch = i / BPC;
      b  = i % BPC;
      return s[ch*CNT_W + (BPC-1-b)*8 +: 8];
   endfunction

   assign hs          = tx_valid_q && tx_ready;
   assign csum_accept = (state_q == RD_CSUM) && hs;
   assign start       = batch_done && ((state_q == RD_IDLE) || csum_accept);
   assign drop        = batch_done && busy_q && !csum_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RD_IDLE;
         snap_q     <= '0;
         idx_q      <= '0;
         seq_q      <= 8'h00;
         csum_q     <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (overrun_clr) begin
            overrun_q <= 1'b0;
         end

         if (start) begin
            state_q    <= RD_HDR;
            snap_q     <= counts;
            tx_data_q  <= FRAME_HDR;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
         end else begin
            case (state_q)
               RD_HDR: begin
                  if (hs) begin
                     state_q   <= RD_SEQ;
                     tx_data_q <= seq_q;
                     csum_q    <= seq_q;
                  end
               end
               RD_SEQ: begin
                  if (hs) begin
                     state_q   <= RD_DATA;
                     idx_q     <= '0;
                     tx_data_q <= snap_byte(snap_q, '0);
                     seq_q     <= seq_q + 8'd1;
                  end
               end
               RD_DATA: begin
                  if (hs) begin
                     csum_q <= csum_q ^ tx_data_q;
                     if (idx_q == LAST_IDX) begin
                        state_q   <= RD_CSUM;
                        tx_data_q <= csum_q ^ tx_data_q;
                     end else begin
                        idx_q     <= idx_q + IDX_ONE;
                        tx_data_q <= snap_byte(snap_q, idx_q + IDX_ONE);
                     end
                  end
               end
               RD_CSUM: begin
                  if (hs) begin
                     state_q    <= RD_IDLE;
                     tx_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                  end
               end
               default: begin
                  state_q <= RD_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_batch_readout.sv
// tb/tb_batch_readout.sv - self-checking bench for batch_readout
// Frame bytes are predicted into a queue at batch_done and popped on each handshake.
module tb_batch_readout;
   import coinc_pkg::*;

   localparam int NCH = NUM_CH_DEF;
   localparam int CW  = CNT_W_DEF;
   localparam int FL  = 3 + NCH * (CW / 8);

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                batch_done = 1'b0;
   logic [NCH*CW-1:0]   counts = '0;
   logic                overrun_clr = 1'b0;
   logic [7:0]          tx_data;
   logic                tx_valid;
   logic                tx_ready = 1'b1;
   logic                busy;
   logic                overrun;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] model_seq = 8'h00;
   int         pos = 0;
   logic [7:0] last_seq = 8'h00;
   logic [7:0] last_csum = 8'h00;
   bit         rnd_ready = 1'b0;
   bit         scramble = 1'b0;
   bit         stall_q = 1'b0;
   logic [7:0] stall_data = 8'h00;

   typedef struct {
      logic [31:0] ch0;
      logic [31:0] rest;
      bit          rnd;
      logic [7:0]  exp_seq;
      logic [7:0]  exp_csum;
   } vec_t;

   vec_t vecs[4];

   batch_readout #(.NUM_CH(NCH), .CNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .batch_done(batch_done),
      .counts(counts),
      .overrun_clr(overrun_clr),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: actual=timeout required=event", name);
   endtask

   function automatic logic [NCH*CW-1:0] make_counts(input logic [31:0] ch0, input logic [31:0] rest);
      logic [NCH*CW-1:0] c;
      c = '0;
      for (int k = 0; k < NCH; k++) c[k*CW +: CW] = (k == 0) ? ch0 : rest;
      return c;
   endfunction

   task automatic push_frame(input logic [NCH*CW-1:0] c);
      logic [7:0] cs;
      logic [7:0] bt;
      exp_q.push_back(8'hA5);
      exp_q.push_back(model_seq);
      cs = model_seq;
      for (int k = 0; k < NCH; k++) begin
         for (int b = CW/8 - 1; b >= 0; b--) begin
            bt = c[k*CW + b*8 +: 8];
            exp_q.push_back(bt);
            cs = cs ^ bt;
         end
      end
      exp_q.push_back(cs);
      model_seq = model_seq + 8'd1;
   endtask

   // Byte scoreboard and hold-rule monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_q) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, stall_data});
         end
         stall_q = tx_valid && !tx_ready;
         stall_data = tx_data;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               check("frame_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            if (pos == 1) last_seq = tx_data;
            if (pos == FL - 1) last_csum = tx_data;
            pos = (pos == FL - 1) ? 0 : pos + 1;
         end
      end else begin
         stall_q = 1'b0;
      end
   end

   // Ready and counter-noise driver, kept clear of the batch_done drive slot.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (scramble && !batch_done) begin
            for (int k = 0; k < NCH; k++) counts[k*CW +: CW] = $urandom();
         end
      end
   end

   task automatic start_frame(input logic [NCH*CW-1:0] c);
      @(posedge clk);
      #1;
      counts = c;
      batch_done = 1'b1;
      push_frame(c);
      @(posedge clk);
      #1;
      batch_done = 1'b0;
      check("start_valid", {31'd0, tx_valid}, 32'd1);
      check("start_hdr", {24'd0, tx_data}, 32'hA5);
      check("start_busy", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_idle(output int cyc);
      bit done;
      cyc = 0;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (busy) cyc++;
         else done = 1'b1;
      end
      if (!done) timeout("wait_idle");
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   task automatic wait_pos(input int p);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(posedge clk);
         #1;
         if (pos >= p) done = 1'b1;
      end
      if (!done) timeout("wait_pos");
   endtask

   initial begin
      int cyc;
      bit found;
      logic [7:0] seq_ff;

      vecs[0] = '{32'h12345678, 32'h00000000, 1'b0, 8'h00, 8'h08};
      vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 8'h01, 8'h01};
      vecs[2] = '{32'hA5A5A5A5, 32'h01020304, 1'b1, 8'h02, 8'h02};
      vecs[3] = '{32'h000000FF, 32'h11111111, 1'b0, 8'h03, 8'hFC};

      #12;
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         rnd_ready = vecs[v].rnd;
         start_frame(make_counts(vecs[v].ch0, vecs[v].rest));
         wait_idle(cyc);
         if (!vecs[v].rnd) check("busy_cycles", cyc, FL);
         check("vec_seq", {24'd0, last_seq}, {24'd0, vecs[v].exp_seq});
         check("vec_csum", {24'd0, last_csum}, {24'd0, vecs[v].exp_csum});
         check("vec_valid_low", {31'd0, tx_valid}, 32'd0);
      end

      // Busy collision: second batch at byte 10 is dropped.
      rnd_ready = 1'b1;
      start_frame(make_counts(32'hCAFEBABE, 32'h0BADF00D));
      wait_pos(10);
      counts = make_counts(32'hDEADBEEF, 32'h55555555);
      batch_done = 1'b1;
      @(posedge clk);
      #1;
      batch_done = 1'b0;
      check("collision_overrun", {31'd0, overrun}, 32'd1);
      wait_idle(cyc);
      check("collision_seq", {24'd0, last_seq}, 32'h04);
      check("overrun_sticky", {31'd0, overrun}, 32'd1);
      start_frame(make_counts(32'h01234567, 32'h89ABCDEF));
      wait_idle(cyc);
      check("after_drop_seq", {24'd0, last_seq}, 32'h05);
      @(posedge clk);
      #1;
      overrun_clr = 1'b1;
      @(posedge clk);
      #1;
      overrun_clr = 1'b0;
      check("overrun_cleared", {31'd0, overrun}, 32'd0);

      // Back-to-back: batch_done on the checksum-accept cycle.
      rnd_ready = 1'b0;
      @(posedge clk);
      start_frame(make_counts(32'h11223344, 32'h00000001));
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 1 && tx_valid) found = 1'b1;
      end
      if (!found) timeout("b2b_csum");
      counts = make_counts(32'h99887766, 32'h00000002);
      batch_done = 1'b1;
      push_frame(counts);
      @(posedge clk);
      #1;
      batch_done = 1'b0;
      check("b2b_hdr", {24'd0, tx_data}, 32'hA5);
      check("b2b_valid", {31'd0, tx_valid}, 32'd1);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      wait_idle(cyc);
      check("b2b_seq", {24'd0, last_seq}, 32'h07);
      check("b2b_overrun", {31'd0, overrun}, 32'd0);

      // Snapshot isolation under changing counters.
      rnd_ready = 1'b1;
      scramble = 1'b1;
      start_frame(make_counts(32'hFEDCBA98, 32'h76543210));
      wait_idle(cyc);
      scramble = 1'b0;

      // Reset mid-frame, then seq restarts and wraps.
      rnd_ready = 1'b0;
      start_frame(make_counts(32'h0F0F0F0F, 32'hF0F0F0F0));
      wait_pos(20);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      model_seq = 8'h00;
      pos = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_frame(make_counts(32'h00000042, 32'h00000000));
      wait_idle(cyc);
      check("post_rst_seq", {24'd0, last_seq}, 32'h00);
      seq_ff = 8'h00;
      for (int f = 0; f < 256; f++) begin
         start_frame(make_counts(f, ~f));
         wait_idle(cyc);
         if (f == 254) seq_ff = last_seq;
      end
      check("wrap_ff", {24'd0, seq_ff}, 32'hFF);
      check("wrap_00", {24'd0, last_seq}, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
